// File: rtl/wb_pipe_reg_pkg.sv
// Shared definitions for the MEM->WB pipeline register: width defaults,
// entry field layout and the steering selectors used by the top.
package wb_pipe_reg_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int RAW_DEF   = 5;
  localparam int CNT_W_DEF = 16;

  // Entry layout, MSB first: {valid, wreg, wd[RAW-1:0], wdata[XLEN-1:0]}
  function automatic int entry_w(input int xlen, input int raw);
    return 2 + raw + xlen;
  endfunction

  typedef enum logic [1:0] {
    MAIN_HOLD,
    MAIN_FROM_SKID,
    MAIN_FROM_IN,
    MAIN_CLEAR
  } main_src_e;

  typedef enum logic [1:0] {
    SKID_HOLD,
    SKID_FROM_IN,
    SKID_CLEAR
  } skid_src_e;

endpackage

// File: rtl/wb_skid_slot.sv
// One writeback storage entry with load/clear. Fields are zeroed whenever the
// entry is invalid, so a reader never sees stale data.
module wb_skid_slot
  import wb_pipe_reg_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RAW  = RAW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            load,
  input  logic            ld_wreg,
  input  logic [RAW-1:0]  ld_wd,
  input  logic [XLEN-1:0] ld_wdata,
  output logic            valid,
  output logic            wreg,
  output logic [RAW-1:0]  wd,
  output logic [XLEN-1:0] wdata
);

  localparam int EW = entry_w(XLEN, RAW);

  logic [EW-1:0] entry;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      entry <= '0;
    end else if (load) begin
      entry <= {1'b1, ld_wreg, ld_wd, ld_wdata};
    end
  end

  assign {valid, wreg, wd, wdata} = entry;

endmodule

// File: rtl/wb_pipe_reg.sv
// MEM->WB pipeline register with valid/ready on both sides and a 2-entry
// skid buffer. Optional stall counter enabled by WB_PIPE_STALL_CNT_EN.
module wb_pipe_reg
  import wb_pipe_reg_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RAW   = RAW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_wreg,
  input  logic [RAW-1:0]   in_wd,
  input  logic [XLEN-1:0]  in_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_wreg,
  output logic [RAW-1:0]   out_wd,
  output logic [XLEN-1:0]  out_wdata
`ifdef WB_PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  logic            main_valid;
  logic            main_wreg;
  logic [RAW-1:0]  main_wd;
  logic [XLEN-1:0] main_wdata;

  logic            skid_valid;
  logic            skid_wreg;
  logic [RAW-1:0]  skid_wd;
  logic [XLEN-1:0] skid_wdata;

  logic            accept;
  logic            main_open;
  main_src_e       main_src;
  skid_src_e       skid_src;

  logic            main_load;
  logic            main_clear;
  logic            main_ld_wreg;
  logic [RAW-1:0]  main_ld_wd;
  logic [XLEN-1:0] main_ld_wdata;
  logic            skid_load;
  logic            skid_clear;

  // in_ready comes straight from the skid flop, so out_ready never reaches it
  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  assign main_open = !main_valid || out_ready;

  always_comb begin
    main_src = MAIN_HOLD;
    skid_src = SKID_HOLD;
    if (flush) begin
      main_src = MAIN_CLEAR;
      skid_src = SKID_CLEAR;
    end else if (main_open) begin
      if (skid_valid) begin
        main_src = MAIN_FROM_SKID;
        skid_src = accept ? SKID_FROM_IN : SKID_CLEAR;
      end else if (accept) begin
        main_src = MAIN_FROM_IN;
      end else begin
        main_src = MAIN_CLEAR;
      end
    end else if (accept) begin
      skid_src = SKID_FROM_IN;
    end
  end

  always_comb begin
    main_load     = (main_src == MAIN_FROM_SKID) || (main_src == MAIN_FROM_IN);
    main_clear    = (main_src == MAIN_CLEAR);
    skid_load     = (skid_src == SKID_FROM_IN);
    skid_clear    = (skid_src == SKID_CLEAR);
    main_ld_wreg  = in_wreg;
    main_ld_wd    = in_wd;
    main_ld_wdata = in_wdata;
    if (main_src == MAIN_FROM_SKID) begin
      main_ld_wreg  = skid_wreg;
      main_ld_wd    = skid_wd;
      main_ld_wdata = skid_wdata;
    end
  end

  wb_skid_slot #(.XLEN(XLEN), .RAW(RAW)) u_main (
    .clk      (clk),
    .rst      (rst),
    .clear    (main_clear),
    .load     (main_load),
    .ld_wreg  (main_ld_wreg),
    .ld_wd    (main_ld_wd),
    .ld_wdata (main_ld_wdata),
    .valid    (main_valid),
    .wreg     (main_wreg),
    .wd       (main_wd),
    .wdata    (main_wdata)
  );

  wb_skid_slot #(.XLEN(XLEN), .RAW(RAW)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .clear    (skid_clear),
    .load     (skid_load),
    .ld_wreg  (in_wreg),
    .ld_wd    (in_wd),
    .ld_wdata (in_wdata),
    .valid    (skid_valid),
    .wreg     (skid_wreg),
    .wd       (skid_wd),
    .wdata    (skid_wdata)
  );

  // Invalid slots already hold zeros; the gating keeps that guarantee local
  assign out_valid = main_valid;
  assign out_wreg  = main_valid & main_wreg;
  assign out_wd    = main_valid ? main_wd : '0;
  assign out_wdata = main_valid ? main_wdata : '0;

`ifdef WB_PIPE_STALL_CNT_EN
  // Saturating count of held cycles; survives flush, cleared only by rst
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = |CNT_W;
`endif

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Self-checking bench for wb_pipe_reg: a 2-deep FIFO model checked every
// cycle, plus literal expectations for reset, streaming, backpressure, flush.
module tb_wb_pipe_reg;

  localparam int XLEN  = 32;
  localparam int RAW   = 5;
  localparam int CNT_W = 4;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic            in_wreg;
  logic [RAW-1:0]  in_wd;
  logic [XLEN-1:0] in_wdata;
  logic            out_valid;
  logic            out_ready;
  logic            out_wreg;
  logic [RAW-1:0]  out_wd;
  logic [XLEN-1:0] out_wdata;
`ifdef WB_PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  wb_pipe_reg #(.XLEN(XLEN), .RAW(RAW), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_wreg   (in_wreg),
    .in_wd     (in_wd),
    .in_wdata  (in_wdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_wreg  (out_wreg),
    .out_wd    (out_wd),
    .out_wdata (out_wdata)
`ifdef WB_PIPE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the stage behaves as a FIFO of depth 2 whose head is the output
  typedef struct packed {
    logic            wreg;
    logic [RAW-1:0]  wd;
    logic [XLEN-1:0] wdata;
  } ent_t;

  ent_t q[$];
  int   m_stall = 0;
  bit   live    = 0;

  always @(posedge clk) begin
    bit acc;
    ent_t e;
    if (rst) begin
      q.delete();
      m_stall = 0;
      live    = 1;
    end else begin
      if (q.size() > 0 && !out_ready && m_stall < (1 << CNT_W) - 1) m_stall++;
      if (flush) begin
        q.delete();
      end else begin
        acc = in_valid && (q.size() < 2);
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (acc) begin
          e.wreg  = in_wreg;
          e.wd    = in_wd;
          e.wdata = in_wdata;
          q.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [XLEN+RAW+2:0] got;
    logic [XLEN+RAW+2:0] exp;
    if (live) begin
      got = {out_valid, out_wreg, out_wd, out_wdata, in_ready};
      if (q.size() > 0) exp = {1'b1, q[0].wreg, q[0].wd, q[0].wdata, q.size() < 2};
      else              exp = {1'b0, 1'b0, {RAW{1'b0}}, {XLEN{1'b0}}, 1'b1};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL model_cycle t=%0t got v/wreg/wd/wdata/rdy=%b/%b/%0d/%h/%b required %b/%b/%0d/%h/%b",
                 $time, got[XLEN+RAW+2], got[XLEN+RAW+1], got[XLEN+RAW:XLEN+1], got[XLEN:1], got[0],
                 exp[XLEN+RAW+2], exp[XLEN+RAW+1], exp[XLEN+RAW:XLEN+1], exp[XLEN:1], exp[0]);
      end
`ifdef WB_PIPE_STALL_CNT_EN
      n_cmp++;
      if (int'(stall_cnt) != m_stall) begin
        n_fail++;
        $display("FAIL model_stall t=%0t got %0d required %0d", $time, stall_cnt, m_stall);
      end
`endif
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %h required %h", name, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input int wd, input logic [XLEN-1:0] wdata);
    in_valid = v;
    in_wreg  = w;
    in_wd    = wd[RAW-1:0];
    in_wdata = wdata;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 1'b0, 0, '0);

    // Reset
    tick(); tick();
    check("reset_outs", {out_valid, out_wreg, out_wd, out_wdata}, 64'h0);
    check("reset_ready", in_ready, 1);
`ifdef WB_PIPE_STALL_CNT_EN
    check("reset_stall", stall_cnt, 0);
`endif
    rst = 1'b0;

    // Streaming
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 1'b1, k, 32'h100 + k);
      tick();
      check($sformatf("stream_%0d", k), {out_valid, out_wreg, out_wd, out_wdata},
            {1'b1, 1'b1, 5'(k), 32'h100 + 32'(k)});
    end
    drive(1'b0, 1'b0, 0, '0);
    tick();
    check("stream_empty", out_valid, 0);

    // Backpressure
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 3, 32'h103); tick();
    drive(1'b1, 1'b1, 4, 32'h104); tick();
    drive(1'b0, 1'b0, 0, '0);
    check("bp_hold_wd", out_wd, 3);
    check("bp_ready_low", in_ready, 0);
    tick(); tick();
    check("bp_still_wd", out_wd, 3);
`ifdef WB_PIPE_STALL_CNT_EN
    check("bp_stall_cnt", stall_cnt, 3);
`endif
    out_ready = 1'b1;
    tick();
    check("bp_second", {out_valid, out_wd, out_wdata}, {1'b1, 5'd4, 32'h104});
    check("bp_ready_back", in_ready, 1);
    tick();
    check("bp_drained", out_valid, 0);

    // Flush with main and skid held and a new entry offered
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 5, 32'h105); tick();
    drive(1'b1, 1'b1, 6, 32'h106); tick();
    drive(1'b1, 1'b1, 7, 32'h107); flush = 1'b1; tick();
    flush = 1'b0;
    drive(1'b0, 1'b0, 0, '0);
    check("flush_outs", {out_valid, out_wreg, out_wd, out_wdata}, 64'h0);
    check("flush_ready", in_ready, 1);
`ifdef WB_PIPE_STALL_CNT_EN
    check("flush_keeps_stall", stall_cnt, 5);
`endif
    out_ready = 1'b1;
    tick();
    check("flush_nothing", out_valid, 0);

    // Bubble entry
    drive(1'b1, 1'b0, 9, 32'hDEAD); tick();
    drive(1'b0, 1'b0, 0, '0);
    check("bubble", {out_valid, out_wreg, out_wd, out_wdata}, {1'b1, 1'b0, 5'd9, 32'hDEAD});
    tick();

    // Long hold for counter saturation
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 10, 32'h10A); tick();
    drive(1'b0, 1'b0, 0, '0);
    for (int k = 0; k < 20; k++) tick();
`ifdef WB_PIPE_STALL_CNT_EN
    check("stall_sat", stall_cnt, 15);
    tick(); tick();
    check("stall_sat_hold", stall_cnt, 15);
`endif
    check("sat_hold_wd", out_wd, 10);
    out_ready = 1'b1;
    tick();

    // Mixed traffic with a flush in the middle
    for (int i = 0; i < 48; i++) begin
      drive((i % 3) != 2, (i % 2) == 1, i, 32'hA000 + 32'(i));
      out_ready = (i % 5) < 3;
      flush     = (i == 30);
      tick();
    end
    flush = 1'b0;
    drive(1'b0, 1'b0, 0, '0);

    // Reset mid-transfer
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 12, 32'h10C); tick();
    drive(1'b0, 1'b0, 0, '0);
    rst = 1'b1; tick();
    check("rst_mid_outs", {out_valid, out_wreg, out_wd, out_wdata}, 64'h0);
    check("rst_mid_ready", in_ready, 1);
    rst = 1'b0;
    out_ready = 1'b1;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
